dly_code_ramp: RTL and testbench

DLY_CODE_RAMP -- requirements
Module: dly_code_ramp

---
 rtl/dly_pkg.sv | 9 +
 rtl/dly_ramp_ch.sv | 44 ++++
 rtl/dly_code_ramp.sv | 68 ++++++
 tb/tb_dly_code_ramp.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dly_pkg.sv
// dly_pkg: shared FSM state type and code-field helpers for the delay-code ramp.
package dly_pkg;
    typedef enum logic {IDLE, RAMP} ch_state_e;
    localparam int DEF_FBW = 6;
    localparam int DEF_CBW = 3;
    function automatic int code_width(input int fbw, input int cbw);
        return fbw + cbw;
    endfunction
endpackage

// File: rtl/dly_ramp_ch.sv
// dly_ramp_ch: one channel, steps its code one LSB per tick toward the latest target.
module dly_ramp_ch
    import dly_pkg::*;
#(
    parameter int CW = 9,
    parameter int RST_CODE = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_wr,
    input  logic [CW-1:0] i_code,
    output logic [CW-1:0] o_cur,
    output logic          o_busy,
    output logic          o_done
);
    ch_state_e     state_q, state_d;
    logic [CW-1:0] cur_q, cur_d, tgt_q, tgt_d;
    logic          done_q, done_d, step;
    // a write in the tick cycle wins; the step is deferred to the next tick
    always_comb begin
        step    = i_tick && state_q == RAMP && !i_wr;
        tgt_d   = i_wr ? i_code : tgt_q;
        cur_d   = !step ? cur_q : (tgt_q > cur_q) ? cur_q + CW'(1) : cur_q - CW'(1);
        state_d = (cur_d != tgt_d) ? RAMP : IDLE;
        done_d  = (i_wr && i_code == cur_q) || (step && cur_d == tgt_q);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cur_q   <= CW'(RST_CODE);
            tgt_q   <= CW'(RST_CODE);
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end
    assign o_cur  = cur_q;
    assign o_busy = cur_q != tgt_q;
    assign o_done = done_q;
endmodule

// File: rtl/dly_code_ramp.sv
// dly_code_ramp: multi-channel delay-code ramp with a shared step tick.
// Define DLY_CLAMP_EN to clamp over-range targets to MAX_CODE instead of dropping them.
module dly_code_ramp
    import dly_pkg::*;
#(
    parameter int NCH = 4,
    parameter int FBW = DEF_FBW,
    parameter int CBW = DEF_CBW,
    parameter int STEP_DIV = 8,
    parameter int RST_CODE = 0,
    parameter int MAX_CODE = 2 ** (FBW + CBW) - 1,
    localparam int CW = code_width(FBW, CBW),
    localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tgt_vld,
    input  logic [CHW-1:0]    i_tgt_ch,
    input  logic [CW-1:0]     i_tgt_code,
    output logic [NCH*CW-1:0] o_dly_sel,
    output logic [NCH-1:0]    o_busy,
    output logic [NCH-1:0]    o_done,
    output logic              o_clamp
);
    localparam int TW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_CODE);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick, over, ld_ok;
    logic [CW-1:0] ld_code;
    always_comb begin
        tick  = cnt_q == TW'(STEP_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + TW'(1);
        over  = i_tgt_code > MAXC;
    end
    always_ff @(posedge i_clk) begin
        cnt_q <= i_rst ? '0 : cnt_d;
    end
`ifdef DLY_CLAMP_EN
    logic clamp_q;
    always_comb begin
        ld_ok   = 1'b1;
        ld_code = over ? MAXC : i_tgt_code;
    end
    // only writes to an existing channel count as clamped
    always_ff @(posedge i_clk) begin
        clamp_q <= !i_rst && i_tgt_vld && over && (int'(i_tgt_ch) < NCH);
    end
    assign o_clamp = clamp_q;
`else
    always_comb begin
        ld_ok   = !over;
        ld_code = i_tgt_code;
    end
    assign o_clamp = 1'b0;
`endif
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        dly_ramp_ch #(.CW(CW), .RST_CODE(RST_CODE)) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_tick (tick),
            .i_wr   (i_tgt_vld && ld_ok && i_tgt_ch == CHW'(k)),
            .i_code (ld_code),
            .o_cur  (o_dly_sel[k*CW +: CW]),
            .o_busy (o_busy[k]),
            .o_done (o_done[k])
        );
    end
endmodule

// File: tb/tb_dly_code_ramp.sv
// tb_dly_code_ramp: scoreboard bench with a cycle-level reference model of the ramp rules.
module tb_dly_code_ramp;
    localparam int NCH = 4, FBW = 6, CBW = 3, CW = 9, SD = 8, RC = 0, MX = 400;
`ifdef DLY_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    logic              clk = 1'b0, rst = 1'b1, vld = 1'b0;
    logic [1:0]        ch = '0;
    logic [CW-1:0]     code = '0;
    logic [NCH*CW-1:0] sel;
    logic [NCH-1:0]    busy, done;
    logic              clamp;

    always #5 clk = ~clk;

    dly_code_ramp #(.NCH(NCH), .FBW(FBW), .CBW(CBW), .STEP_DIV(SD), .RST_CODE(RC), .MAX_CODE(MX)) dut (
        .i_clk(clk), .i_rst(rst), .i_tgt_vld(vld), .i_tgt_ch(ch), .i_tgt_code(code),
        .o_dly_sel(sel), .o_busy(busy), .o_done(done), .o_clamp(clamp)
    );

    typedef struct {
        logic [NCH*CW-1:0] sel;
        logic [NCH-1:0]    busy;
        logic [NCH-1:0]    done;
        logic              clamp;
    } exp_t;
    exp_t q[$];
    int errs = 0, checks = 0;
    int cur[NCH], tgt[NCH], cnt = 0;

    // drive one cycle of inputs and queue what the outputs must be after the next edge
    task automatic cyc(input bit r, input bit v, input int c, input int d);
        exp_t e;
        bit tick;
        @(negedge clk);
        rst = r; vld = v; ch = 2'(c); code = CW'(d);
        e.clamp = 1'b0;
        e.done = '0;
        if (r) begin
            cnt = 0;
            for (int k = 0; k < NCH; k++) begin cur[k] = RC; tgt[k] = RC; end
        end else begin
            tick = cnt == SD - 1;
            cnt = (cnt + 1) % SD;
            for (int k = 0; k < NCH; k++) begin
                if (v && c == k && (d <= MX || CLAMP)) begin
                    tgt[k] = d > MX ? MX : d;
                    e.done[k] = tgt[k] == cur[k];
                    e.clamp = d > MX;
                end else if (tick && cur[k] != tgt[k]) begin
                    cur[k] += tgt[k] > cur[k] ? 1 : -1;
                    e.done[k] = cur[k] == tgt[k];
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            e.sel[k*CW +: CW] = CW'(cur[k]);
            e.busy[k] = cur[k] != tgt[k];
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic wr(input int c, input int d);
        cyc(0, 1, c, d);
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, x, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dly_sel", 64'(sel), 64'(e.sel));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("done", 64'(done), 64'(e.done));
                chk("clamp", 64'(clamp), 64'(e.clamp));
            end
        end
    end

    initial begin : driver
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 7);
        idle(3);
        wr(0, 10);
        idle(100);
        wr(2, 63);
        idle(520);
        wr(2, 66);
        idle(40);
        wr(2, 62);
        idle(50);
        wr(1, 20);
        for (int i = 0; i < 200 && cur[1] != 5; i++) idle(1);
        wr(1, 2);
        idle(40);
        for (int i = 0; i < 20 && cnt != SD - 1; i++) idle(1);
        wr(3, 30);
        idle(30);
        wr(3, 30);
        idle(3);
        wr(0, 500);
        idle(3300);
        wr(0, 3); wr(1, 40); wr(2, 90); wr(3, 0);
        idle(30);
        cyc(1, 1, 2, 5);
        idle(20);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(499) == 0, $urandom_range(3) == 0, $urandom_range(3), $urandom_range(511));
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(999) == 0, $urandom_range(15) == 0, $urandom_range(3), $urandom_range(40));
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain got=%0d exp=0 pending", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
